sc_stream_to_bin_decoder: RTL and testbench
===========================================

// Module: sc_stream_to_bin_decoder
// PURPOSE
//  Stochastic/unary-bitstream to binary decoder: reader side of the bitstream encoders feeding the
//  arch-sweep multiplier cores. Counts ones on NUM_INPUTS parallel lanes over a 2^DATA_WIDTH-bit
//  window and presents each lane's count as a binary word with a one-cycle done pulse.
//  Sits between the stochastic datapath and the binary scoreboard/result capture.
// PARAMETERS
//  DATA_WIDTH  5  log2 of stream length; window = 2^DATA_WIDTH valid bits
//  NUM_INPUTS  2  number of parallel bitstream lanes
//  WXIP1       6  output width per lane; exact when WXIP1 >= DATA_WIDTH+1, else saturating
// PORTS
//  clk           in   1                  single clock, rising edge
//  rst           in   1                  asynchronous, active-low reset
//  en            in   1                  start request; sampled in IDLE or DONE
//  stream_valid  in   1                  qualifies stream_in this cycle (stall when 0)
//  stream_in     in   [NUM_INPUTS-1:0]   one bitstream bit per lane
//  bin_data_out  out  [WXIP1-1:0] x NUM_INPUTS (unpacked)  per-lane ones count
//  done          out  1                  one-cycle pulse: bin_data_out updated
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, bit counter=0, lane accumulators=0, bin_data_out=0, done=0.
//  FSM: IDLE --en--> RUN; RUN --last valid bit sampled--> DONE; DONE --en--> RUN, else --> IDLE.
//  On IDLE/DONE->RUN: bit counter and all lane accumulators cleared.
//  RUN: when stream_valid=1, acc[i] += stream_in[i], bit counter += 1. stream_valid=0: hold all.
//  en is ignored while in RUN (no restart, no abort).
//  Last bit = valid bit with counter == 2^DATA_WIDTH-1; counter width DATA_WIDTH, wraps to 0.
//  Entering DONE: bin_data_out[i] <= acc[i] including last bit; done=1 for exactly that cycle.
//  Latency: en in cycle t -> first bit sampled at t+1 earliest; done one cycle after last bit.
//  bin_data_out holds its value from the done cycle until the next done or reset (not cleared at start).
//  Width rule: acc is DATA_WIDTH+1 bits internally (max 2^DATA_WIDTH). If WXIP1 < DATA_WIDTH+1,
//   output = min(acc, 2^WXIP1-1) (saturate, never wrap). If WXIP1 > DATA_WIDTH+1, zero-extend.
//  Back-to-back: en=1 in DONE cycle -> RUN next cycle, no idle gap; done pulses do not merge.
//  Reset mid-RUN: partial counts discarded, bin_data_out=0, done never asserted for that window.
//  Elaboration checks: DATA_WIDTH >= 1, NUM_INPUTS >= 1, WXIP1 >= 1.
// STRUCTURE
//  sc_pkg (shared): typedef enum logic [1:0] {SC_IDLE, SC_RUN, SC_DONE} sc_state_t;
//   function sc_sat(acc, width) for saturating narrowing, reused by other decoders.
//  Sub-module sc_lane_counter (one per lane, generate loop): clear/inc-enable accumulator,
//   DATA_WIDTH+1 bits, saturating output of WXIP1 bits. FSM + bit counter live in the top.
// TESTING (DATA_WIDTH=5, NUM_INPUTS=2, WXIP1=6 unless noted)
//  1 lane0 all 1s, lane1 all 0s, valid=1 for 32 cycles -> done once, out[0]=32, out[1]=0.
//  2 lane0 1010.., lane1 1 every 4th bit, valid=1 -> out[0]=16, out[1]=8; done 1 cycle after 32nd bit.
//  3 same as 1 with valid=0 on 10 random cycles (stream_in toggled then) -> out[0]=32, done 10 cycles later.
//  4 en held high through done -> second window starts next cycle; two done pulses 33 cycles apart,
//    out holds window-1 value until 2nd done.
//  5 rst=0 after 20 bits -> out=0, done=0 immediately (async); fresh window after en -> correct count.
//  6 WXIP1=5, lane0 all 1s -> out[0]=31 (saturated); lane1 with 17 ones -> 17.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-to-binary decoders.
package sc_pkg;

  typedef enum logic [1:0] {SC_IDLE, SC_RUN, SC_DONE} sc_state_t;

  // Clamp acc to the largest value representable in width bits.
  function automatic logic [31:0] sc_sat(input logic [31:0] acc, input int unsigned width);
    logic [31:0] lim;
    lim = '1;
    if (width < 32) lim = (32'd1 << width) - 32'd1;
    return (acc > lim) ? lim : acc;
  endfunction

endpackage

// File: rtl/sc_lane_counter.sv
// One lane: ones accumulator with clear/increment and a saturated look-ahead count.
module sc_lane_counter
  import sc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned WXIP1      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  input  logic             bit_in,
  output logic [WXIP1-1:0] count_next
);

  localparam int unsigned AW = DATA_WIDTH + 1;

  logic [AW-1:0] acc;
  logic [AW-1:0] acc_next;

  always_comb begin
    acc_next = acc;
    if (inc && bit_in) acc_next = acc + AW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       acc <= '0;
    else if (clear) acc <= '0;
    else            acc <= acc_next;
  end

  // Exposes the count including this cycle's bit so the top can latch it on the last bit.
  always_comb count_next = WXIP1'(sc_sat(32'(acc_next), WXIP1));

endmodule

// File: rtl/sc_stream_to_bin_decoder.sv
// Counts ones per lane over a 2^DATA_WIDTH valid-bit window; publishes counts with a done pulse.
module sc_stream_to_bin_decoder
  import sc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned NUM_INPUTS = 2,
  parameter int unsigned WXIP1      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  stream_valid,
  input  logic [NUM_INPUTS-1:0] stream_in,
  output logic [WXIP1-1:0]      bin_data_out [NUM_INPUTS],
  output logic                  done
);

  if (DATA_WIDTH < 1) begin : g_bad_dw
    $error("DATA_WIDTH must be >= 1");
  end
  if (NUM_INPUTS < 1) begin : g_bad_ni
    $error("NUM_INPUTS must be >= 1");
  end
  if (WXIP1 < 1) begin : g_bad_w
    $error("WXIP1 must be >= 1");
  end

  sc_state_t             state;
  logic [DATA_WIDTH-1:0] bit_cnt;
  logic                  start;
  logic                  step;
  logic                  last;
  logic [WXIP1-1:0]      lane_next [NUM_INPUTS];

  always_comb begin
    start = (state != SC_RUN) && en;
    step  = (state == SC_RUN) && stream_valid;
    last  = step && (bit_cnt == '1);
  end

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    sc_lane_counter #(
      .DATA_WIDTH (DATA_WIDTH),
      .WXIP1      (WXIP1)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .clear      (start),
      .inc        (step),
      .bit_in     (stream_in[i]),
      .count_next (lane_next[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= SC_IDLE;
      bit_cnt <= '0;
      done    <= 1'b0;
      for (int unsigned i = 0; i < NUM_INPUTS; i++) bin_data_out[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        SC_IDLE: begin
          if (en) begin
            state   <= SC_RUN;
            bit_cnt <= '0;
          end
        end
        SC_RUN: begin
          if (stream_valid) begin
            bit_cnt <= bit_cnt + DATA_WIDTH'(1);
            if (last) begin
              state <= SC_DONE;
              done  <= 1'b1;
              for (int unsigned i = 0; i < NUM_INPUTS; i++) bin_data_out[i] <= lane_next[i];
            end
          end
        end
        SC_DONE: begin
          if (en) begin
            state   <= SC_RUN;
            bit_cnt <= '0;
          end else begin
            state <= SC_IDLE;
          end
        end
        default: state <= SC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_stream_to_bin_decoder.sv
// Directed scoreboard bench: exact-width (WXIP1=6) and saturating (WXIP1=5) decoders in parallel.
module tb_sc_stream_to_bin_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       stream_valid = 1'b0;
  logic [1:0] stream_in = '0;
  logic [5:0] out_a [2];
  logic [4:0] out_b [2];
  logic       done_a, done_b;

  int unsigned cmp_count = 0;
  int unsigned mis_count = 0;
  int unsigned done_seen = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned a0, a1, b0, b1;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sc_stream_to_bin_decoder #(.DATA_WIDTH(5), .NUM_INPUTS(2), .WXIP1(6)) dut_a (
    .clk(clk), .rst(rst), .en(en), .stream_valid(stream_valid),
    .stream_in(stream_in), .bin_data_out(out_a), .done(done_a)
  );

  sc_stream_to_bin_decoder #(.DATA_WIDTH(5), .NUM_INPUTS(2), .WXIP1(5)) dut_b (
    .clk(clk), .rst(rst), .en(en), .stream_valid(stream_valid),
    .stream_in(stream_in), .bin_data_out(out_b), .done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    cmp_count++;
    assert (obs === expv) else begin
      mis_count++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int unsigned sat(input int unsigned v, input int unsigned lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic push_exp(input logic [31:0] p0, input logic [31:0] p1);
    exp_t e;
    e.a0 = $countones(p0);
    e.a1 = $countones(p1);
    e.b0 = sat(e.a0, 31);
    e.b1 = sat(e.a1, 31);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst && (done_a || done_b)) chk("done_sync", done_b, done_a);
    if (rst && done_a) begin
      exp_t e;
      done_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_a0", out_a[0], e.a0);
        chk("out_a1", out_a[1], e.a1);
        chk("out_b0", out_b[0], e.b0);
        chk("out_b1", out_b[1], e.b1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_window();
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  // Drives 32 valid bits (bit k of each pattern on the k-th valid cycle) with stall cycles mixed in.
  task automatic run_bits(input logic [31:0] p0, input logic [31:0] p1,
                          input int unsigned stalls, output int unsigned cycles);
    cycles = 0;
    for (int k = 0; k < 32; k++) begin
      while (stalls > 0 && (k == 31 || $urandom_range(0, 3) == 0)) begin
        stream_valid = 1'b0;
        stream_in    = 2'($urandom);
        tick();
        cycles++;
        stalls--;
      end
      stream_valid = 1'b1;
      stream_in    = {p1[k], p0[k]};
      tick();
      cycles++;
    end
    stream_valid = 1'b0;
    stream_in    = '0;
  endtask

  initial begin
    int unsigned n;
    int unsigned c1, c2;

    repeat (3) tick();
    chk("reset_done", done_a, 0);
    chk("reset_out_a0", out_a[0], 0);
    chk("reset_out_a1", out_a[1], 0);
    chk("reset_out_b0", out_b[0], 0);
    rst = 1'b1;
    tick();

    // Test 1: lane0 all ones, lane1 all zeros
    push_exp(32'hFFFF_FFFF, 32'h0000_0000);
    start_window();
    run_bits(32'hFFFF_FFFF, 32'h0000_0000, 0, n);
    chk("t1_done_timing", done_a, 1);
    chk("t1_cycles", n, 32);
    tick();
    chk("t1_done_pulse", done_a, 0);

    // Test 2: alternating lane0, every 4th bit on lane1
    push_exp(32'h5555_5555, 32'h1111_1111);
    start_window();
    run_bits(32'h5555_5555, 32'h1111_1111, 0, n);
    chk("t2_done_timing", done_a, 1);
    tick();
    chk("t2_done_pulse", done_a, 0);

    // Test 3: ten stall cycles with noise on stream_in
    push_exp(32'hFFFF_FFFF, 32'h0000_0000);
    start_window();
    run_bits(32'hFFFF_FFFF, 32'h0000_0000, 10, n);
    chk("t3_done_timing", done_a, 1);
    chk("t3_cycles", n, 42);
    tick();

    // Test 4: en held high, back-to-back windows
    en = 1'b1;
    tick();
    push_exp(32'h0000_FFFF, 32'hFFFF_FFFF);
    run_bits(32'h0000_FFFF, 32'hFFFF_FFFF, 0, n);
    c1 = cyc;
    chk("t4_done1", done_a, 1);
    push_exp(32'h0000_0007, 32'h0000_0001);
    tick();
    chk("t4_done1_pulse", done_a, 0);
    chk("t4_hold_a0", out_a[0], 16);
    chk("t4_hold_a1", out_a[1], 32);
    run_bits(32'h0000_0007, 32'h0000_0001, 0, n);
    c2 = cyc;
    chk("t4_done2", done_a, 1);
    chk("t4_spacing", c2 - c1, 33);
    en = 1'b0;
    tick();
    chk("t4_done2_pulse", done_a, 0);
    tick();

    // Test 5: async reset after 20 bits discards the window
    start_window();
    for (int k = 0; k < 20; k++) begin
      stream_valid = 1'b1;
      stream_in    = 2'b11;
      tick();
    end
    #2;
    rst = 1'b0;
    #1;
    chk("t5_rst_done", done_a, 0);
    chk("t5_rst_a0", out_a[0], 0);
    chk("t5_rst_a1", out_a[1], 0);
    chk("t5_rst_b0", out_b[0], 0);
    stream_valid = 1'b0;
    stream_in    = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    push_exp(32'hAAAA_AAAA, 32'h0F0F_0F0F);
    start_window();
    run_bits(32'hAAAA_AAAA, 32'h0F0F_0F0F, 0, n);
    chk("t5_done_timing", done_a, 1);
    tick();

    // Test 6: saturation on the narrow instance, 17 ones on lane1
    push_exp(32'hFFFF_FFFF, 32'h0001_FFFF);
    start_window();
    run_bits(32'hFFFF_FFFF, 32'h0001_FFFF, 0, n);
    chk("t6_done_timing", done_a, 1);
    tick();
    repeat (3) tick();

    chk("queue_empty", exp_q.size(), 0);
    chk("done_pulses", done_seen, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, mis_count);
    $finish;
  end

endmodule
